// File: rtl/dco_nco_if.sv
// Control/status bundle for the multi-phase NCO: handshaked control codes in,
// phase clocks and tuning status out.
interface dco_nco_if #(
    parameter int NCTRL  = 32'sd4,
    parameter int CTRL_W = 32'sd12,
    parameter int ACC_W  = 32'sd16,
    parameter int NPHASE = 32'sd4
);
    logic                          en;
    logic [NCTRL-1:0][CTRL_W-1:0]  ctrl;
    logic                          ctrl_valid;
    logic                          ctrl_ready;
    logic [NPHASE-1:0]             pclk;
    logic                          wrap;
    logic [ACC_W-1:0]              fcw_act;
    logic                          sat_hi;
    logic                          sat_lo;
    logic                          running;

    modport master (
        output en, ctrl, ctrl_valid,
        input  ctrl_ready, pclk, wrap, fcw_act, sat_hi, sat_lo, running
    );

    modport slave (
        input  en, ctrl, ctrl_valid,
        output ctrl_ready, pclk, wrap, fcw_act, sat_hi, sat_lo, running
    );
endinterface

// File: rtl/dco_nco.sv
// Multi-phase NCO: clamped weighted control sum retunes the accumulator only at phase wrap.
// Optional period-jitter LFSR dither is enabled by defining DCO_NCO_DITHER_EN.
module dco_nco #(
    parameter int NCTRL          = 32'sd4,
    parameter int CTRL_W         = 32'sd12,
    parameter int KSHIFT [NCTRL] = '{32'sd12, 32'sd8, 32'sd4, 32'sd0},
    parameter int ACC_W          = 32'sd16,
    parameter int F0_FCW         = 32'sd4096,
    parameter int FCW_MIN        = 32'sd256,
    parameter int FCW_MAX        = 32'sd32768,
    parameter int NPHASE         = 32'sd4
) (
    input  logic     clk,
    input  logic     resetn,
    dco_nco_if.slave bus
);
    localparam int SUM_W   = ACC_W + CTRL_W + 32'sd4;
    localparam int PH_STEP = (32'sd1 <<< ACC_W) / NPHASE;
    localparam logic signed [SUM_W-1:0] F0_S   = SUM_W'(F0_FCW);
    localparam logic signed [SUM_W-1:0] FMIN_S = SUM_W'(FCW_MIN);
    localparam logic signed [SUM_W-1:0] FMAX_S = SUM_W'(FCW_MAX);

    // Returns {sat_hi, sat_lo, fcw} for a signed wide sum.
    function automatic logic [ACC_W+1:0] clamp_fcw(input logic signed [SUM_W-1:0] s);
        logic [ACC_W+1:0] r;
        if (s > FMAX_S) begin
            r = {1'b1, 1'b0, FMAX_S[ACC_W-1:0]};
        end else if (s < FMIN_S) begin
            r = {1'b0, 1'b1, FMIN_S[ACC_W-1:0]};
        end else begin
            r = {2'b00, s[ACC_W-1:0]};
        end
        return r;
    endfunction

    localparam logic [ACC_W+1:0] F0_CLAMP = clamp_fcw(F0_S);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} state_t;

    state_t                  state_r, state_nxt_s;
    logic [ACC_W-1:0]        acc_r, acc_d_s, acc_next_s, ph_s;
    logic [ACC_W-1:0]        fcw_act_r, pend_fcw_r;
    logic [ACC_W:0]          inc_s, step_s;
    logic                    carry_s, wrap_r, wrap_d_s;
    logic                    pend_r, sat_hi_r, sat_lo_r, accept_s, apply_s;
    logic [NPHASE-1:0]       pclk_r, pclk_d_s, phase_s;
    logic signed [SUM_W-1:0] sum_s;
    logic [ACC_W+1:0]        clamp_s;

`ifdef DCO_NCO_DITHER_EN
    logic [15:0] lfsr_r;
    logic        lfsr_adv_s;
    assign lfsr_adv_s = (state_r != IDLE);
    assign inc_s      = {1'b0, fcw_act_r} + {{(ACC_W-1){1'b0}}, lfsr_r[1:0]};
`else
    assign inc_s      = {1'b0, fcw_act_r};
`endif

    assign step_s     = {1'b0, acc_r} + inc_s;
    assign carry_s    = step_s[ACC_W];
    assign acc_next_s = step_s[ACC_W-1:0];
    assign accept_s   = bus.ctrl_valid && !pend_r;
    assign clamp_s    = clamp_fcw(sum_s);

    // Weighted sum of the sign-extended control codes around the centre word.
    always_comb begin
        sum_s = F0_S;
        for (int i = 0; i < NCTRL; i++) begin
            sum_s = sum_s + ({{(SUM_W-CTRL_W){bus.ctrl[i][CTRL_W-1]}}, bus.ctrl[i]} << KSHIFT[i]);
        end
    end

    // Phase taps: MSB of the next accumulator value offset by k/NPHASE of a turn.
    always_comb begin
        phase_s = '0;
        ph_s    = '0;
        for (int k = 0; k < NPHASE; k++) begin
            ph_s       = acc_next_s + ACC_W'(k * PH_STEP);
            phase_s[k] = ph_s[ACC_W-1];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state; STOP keeps running until the turn completes unless re-enabled.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.en) state_nxt_s = RUN;
                else        state_nxt_s = IDLE;
            end
            RUN: begin
                if (!bus.en) state_nxt_s = STOP;
                else         state_nxt_s = RUN;
            end
            STOP: begin
                if (bus.en)       state_nxt_s = RUN;
                else if (carry_s) state_nxt_s = IDLE;
                else              state_nxt_s = STOP;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs: accumulator/phase next values and when a pending code is applied.
    always_comb begin
        acc_d_s  = acc_r;
        wrap_d_s = 1'b0;
        pclk_d_s = '0;
        apply_s  = 1'b0;
        case (state_r)
            IDLE: begin
                acc_d_s = '0;
                apply_s = bus.en && pend_r;
            end
            RUN, STOP: begin
                wrap_d_s = carry_s;
                apply_s  = carry_s && pend_r;
                if (state_nxt_s == IDLE) begin
                    acc_d_s  = '0;
                    pclk_d_s = '0;
                end else begin
                    acc_d_s  = acc_next_s;
                    pclk_d_s = phase_s;
                end
            end
            default: begin
                acc_d_s = '0;
            end
        endcase
    end

    // Accumulator, phase clocks and wrap pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_r  <= '0;
            pclk_r <= '0;
            wrap_r <= 1'b0;
        end else begin
            acc_r  <= acc_d_s;
            pclk_r <= pclk_d_s;
            wrap_r <= wrap_d_s;
        end
    end

    // Single pending slot; accept and apply are exclusive because both depend on pend_r.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_r     <= 1'b0;
            pend_fcw_r <= '0;
            fcw_act_r  <= F0_CLAMP[ACC_W-1:0];
            sat_hi_r   <= 1'b0;
            sat_lo_r   <= 1'b0;
        end else if (accept_s) begin
            pend_r     <= 1'b1;
            pend_fcw_r <= clamp_s[ACC_W-1:0];
            sat_hi_r   <= clamp_s[ACC_W+1];
            sat_lo_r   <= clamp_s[ACC_W];
        end else if (apply_s) begin
            pend_r    <= 1'b0;
            fcw_act_r <= pend_fcw_r;
        end else begin
            pend_r <= pend_r;
        end
    end

`ifdef DCO_NCO_DITHER_EN
    // Galois LFSR x^16+x^14+x^13+x^11+1, stepped only while oscillating.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_r <= 16'hACE1;
        end else if (lfsr_adv_s) begin
            lfsr_r <= {1'b0, lfsr_r[15:1]} ^ (lfsr_r[0] ? 16'hB400 : 16'h0000);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end
`endif

    assign bus.ctrl_ready = !pend_r;
    assign bus.pclk       = pclk_r;
    assign bus.wrap       = wrap_r;
    assign bus.fcw_act    = fcw_act_r;
    assign bus.sat_hi     = sat_hi_r;
    assign bus.sat_lo     = sat_lo_r;
    assign bus.running    = (state_r != IDLE);
endmodule

// File: tb/tb_dco_nco.sv
// Scoreboard bench for dco_nco: expected wrap events and phase snapshots are queued
// by the stimulus and checked by an independent negedge monitor.
module tb_dco_nco;
    localparam int NCTRL = 4, CTRL_W = 12, ACC_W = 16, NPHASE = 4;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   cyc    = 0;
    int   base   = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    typedef struct { int fcw; int period; int hi; int sh; int sl; } wrap_t;
    typedef struct { int at; int pclk; } snap_t;
    wrap_t wrap_q[$];
    snap_t snap_q[$];

    dco_nco_if #(.NCTRL(NCTRL), .CTRL_W(CTRL_W), .ACC_W(ACC_W), .NPHASE(NPHASE)) bus ();
    dco_nco dut (.clk(clk), .resetn(resetn), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0d)", name, act, exp, cyc - base);
        end
    endtask

    // period 0 and hi -1 mean "not checked" for that wrap.
    task automatic exp_wrap(input int fcw, input int period, input int hi, input int sh, input int sl);
        wrap_q.push_back('{fcw, period, hi, sh, sl});
    endtask

    task automatic exp_snap(input int t, input int p);
        snap_q.push_back('{base + t, p});
    endtask

    task automatic wait_until(input int t);
        while (cyc < base + t) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : monitor
        wrap_t w;
        snap_t s;
        int    last_wrap;
        int    hi_cnt;
        last_wrap = 0;
        hi_cnt    = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                hi_cnt = 0;
            end else begin
                if (bus.pclk[0]) hi_cnt++;
                if (snap_q.size() > 0 && cyc == snap_q[0].at) begin
                    s = snap_q.pop_front();
                    check("pclk_phases", int'(bus.pclk), s.pclk);
                end
                if (bus.wrap) begin
                    if (wrap_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_wrap: got a wrap, expected none (t=%0d)", cyc - base);
                    end else begin
                        w = wrap_q.pop_front();
                        check("wrap_fcw", int'(bus.fcw_act), w.fcw);
                        check("wrap_sat_hi", int'(bus.sat_hi), w.sh);
                        check("wrap_sat_lo", int'(bus.sat_lo), w.sl);
                        if (w.period > 0) check("wrap_period", cyc - last_wrap, w.period);
                        if (w.hi >= 0) check("pclk0_high_cycles", hi_cnt, w.hi);
                    end
                    last_wrap = cyc;
                    hi_cnt    = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bus.en = 1'b0;
        bus.ctrl = '0;
        bus.ctrl_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pclk", int'(bus.pclk), 0);
        check("rst_wrap", int'(bus.wrap), 0);
        check("rst_fcw", int'(bus.fcw_act), 4096);
        check("rst_sat_hi", int'(bus.sat_hi), 0);
        check("rst_sat_lo", int'(bus.sat_lo), 0);
        check("rst_running", int'(bus.running), 0);
        check("rst_ready", int'(bus.ctrl_ready), 1);
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_running", int'(bus.running), 0);

        // Start at the centre frequency: 16-cycle period, quarter-period phase leads.
        base = cyc;
        bus.en = 1'b1;
        exp_wrap(4096, 0, -1, 0, 0);
        exp_wrap(4096, 16, 8, 0, 0);
        exp_snap(19, 4'b1100);
        exp_snap(23, 4'b0110);
        exp_snap(27, 4'b0011);
        exp_snap(31, 4'b1001);
        wait_until(1);
        check("start_running", int'(bus.running), 1);
        check("start_fcw", int'(bus.fcw_act), 4096);

        // Retune mid-period to 8192; applies at the wrap at t=49.
        exp_wrap(8192, 16, 8, 0, 0);
        exp_wrap(8192, 8, 4, 0, 0);
        wait_until(37);
        bus.ctrl[0] = 12'd1;
        bus.ctrl_valid = 1'b1;
        wait_until(38);
        bus.ctrl_valid = 1'b0;
        bus.ctrl = '0;
        wait_until(40);
        check("retune_ready_low", int'(bus.ctrl_ready), 0);
        check("retune_fcw_held", int'(bus.fcw_act), 4096);
        wait_until(48);
        check("retune_ready_before_wrap", int'(bus.ctrl_ready), 0);
        wait_until(49);
        check("retune_ready_after_wrap", int'(bus.ctrl_ready), 1);

        // Clamp high.
        exp_wrap(32768, 8, 4, 1, 0);
        exp_wrap(32768, 2, 1, 1, 0);
        exp_wrap(32768, 2, 1, 1, 0);
        wait_until(59);
        bus.ctrl[0] = 12'd2047;
        bus.ctrl_valid = 1'b1;
        wait_until(60);
        bus.ctrl_valid = 1'b0;
        bus.ctrl = '0;
        wait_until(61);
        check("clamp_hi_sat_hi", int'(bus.sat_hi), 1);
        check("clamp_hi_sat_lo", int'(bus.sat_lo), 0);

        // Clamp low, accepted on the same edge as a wrap: applied one wrap later.
        exp_wrap(32768, 2, 1, 0, 1);
        exp_wrap(256, 2, 1, 0, 1);
        exp_wrap(8192, 256, 128, 0, 0);
        wait_until(70);
        bus.ctrl[0] = 12'hFFE;
        bus.ctrl_valid = 1'b1;
        wait_until(71);
        bus.ctrl_valid = 1'b0;
        bus.ctrl = '0;

        // Back-to-back: second code waits until the first is applied.
        exp_wrap(16384, 8, 4, 0, 0);
        exp_wrap(16384, 4, 2, 0, 0);
        exp_wrap(16384, 4, 2, 0, 0);
        wait_until(80);
        bus.ctrl[0] = 12'd1;
        bus.ctrl_valid = 1'b1;
        wait_until(81);
        bus.ctrl[0] = 12'd3;
        wait_until(82);
        check("b2b_ready_low", int'(bus.ctrl_ready), 0);
        wait_until(328);
        check("b2b_ready_before_apply", int'(bus.ctrl_ready), 0);
        wait_until(329);
        check("b2b_ready_after_apply", int'(bus.ctrl_ready), 1);
        wait_until(330);
        check("b2b_second_accepted", int'(bus.ctrl_ready), 0);
        bus.ctrl_valid = 1'b0;
        bus.ctrl = '0;

        // Stop: finishes the turn, then idles.
        wait_until(342);
        bus.en = 1'b0;
        wait_until(344);
        check("stop_still_running", int'(bus.running), 1);
        wait_until(346);
        check("stop_idle_running", int'(bus.running), 0);
        check("stop_idle_pclk", int'(bus.pclk), 0);

        // Restart, queue a code, then reset mid-run: pending code is lost.
        exp_wrap(16384, 0, -1, 0, 0);
        exp_wrap(16384, 4, 2, 0, 0);
        wait_until(350);
        bus.en = 1'b1;
        wait_until(359);
        bus.ctrl[0] = 12'd2047;
        bus.ctrl_valid = 1'b1;
        wait_until(360);
        bus.ctrl_valid = 1'b0;
        bus.ctrl = '0;
        check("pre_rst_sat_hi", int'(bus.sat_hi), 1);
        check("pre_rst_ready", int'(bus.ctrl_ready), 0);
        wait_until(361);
        resetn = 1'b0;
        #1;
        check("async_rst_running", int'(bus.running), 0);
        check("async_rst_pclk", int'(bus.pclk), 0);
        check("async_rst_ready", int'(bus.ctrl_ready), 1);
        check("async_rst_fcw", int'(bus.fcw_act), 4096);
        check("async_rst_sat_hi", int'(bus.sat_hi), 0);
        exp_wrap(4096, 0, -1, 0, 0);
        exp_wrap(4096, 16, 8, 0, 0);
        exp_wrap(4096, 16, 8, 0, 0);
        wait_until(363);
        resetn = 1'b1;

        // STOP then re-enable before the wrap: no phase discontinuity.
        wait_until(382);
        bus.en = 1'b0;
        wait_until(385);
        check("resume_running", int'(bus.running), 1);
        bus.en = 1'b1;
        wait_until(400);
        bus.en = 1'b0;
        wait_until(413);
        check("final_idle_running", int'(bus.running), 0);
        check("final_idle_pclk", int'(bus.pclk), 0);
        wait_until(420);
        check("all_wraps_seen", wrap_q.size(), 0);
        check("all_snaps_seen", snap_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
